// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmitter and its CRC16 helper.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_DATA0 = 3'd1,
    CMD_DATA1 = 3'd2,
    CMD_ACK   = 3'd3,
    CMD_NAK   = 3'd4,
    CMD_STALL = 3'd5
  } tx_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP_SE0, S_EOP_J
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Bits leave LSB first, so the serial register runs in reflected form.
  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 (reflected, LSB-first input); output is the complemented register,
// whose low byte goes on the wire first.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  localparam logic [15:0] POLY_R = reflect16(CRC16_POLY);

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      r_crc <= CRC16_INIT;
    else if (i_clr)  r_crc <= CRC16_INIT;
    else if (i_en)   r_crc <= (r_crc >> 1) ^ ((r_crc[0] ^ i_bit) ? POLY_R : 16'h0000);
  end

  assign o_crc = ~r_crc;

endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, PID, payload, CRC16, EOP with NRZI and
// bit stuffing, pulling payload bytes from the TX buffer one bit period ahead.
module usb_tx
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [6:0] MAX_P = 7'(MAX_PAYLOAD);

  tx_state_e        r_state, w_nxt_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_idx, w_nxt_idx;
  logic [7:0]       r_shift, w_nxt_shift;
  logic [7:0]       r_next_byte;
  logic [7:0]       r_pid, w_nxt_pid;
  logic [2:0]       r_ones, w_nxt_ones;
  logic             r_stuff, w_nxt_stuff;
  logic [6:0]       r_count, w_nxt_count;
  logic [6:0]       r_byte_cnt, w_nxt_byte_cnt;
  logic             r_is_data, w_nxt_is_data;
  logic             r_line, w_nxt_line;
  logic             r_se0, w_nxt_se0;
  logic             r_err, w_err;
  logic             w_tick, w_load, w_raw, w_nxt_raw, w_get;
  logic [15:0]      w_crc;

  assign w_tick = (r_clk_cnt == LAST_CLK);
  assign w_raw  = r_stuff ? 1'b0 : r_shift[r_idx];

  usb_crc16 u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .i_clr (r_state == S_SYNC),
    .i_en  ((r_state == S_DATA) && (r_clk_cnt == '0) && !r_stuff),
    .i_bit (r_shift[r_idx]),
    .o_crc (w_crc)
  );

  // Pop during the first cycle of the last real bit of the byte before each payload byte.
  always_comb begin
    w_get = 1'b0;
    if ((r_clk_cnt == '0) && !r_stuff && (r_idx == 3'd7)) begin
      if (r_state == S_PID)  w_get = r_is_data && (r_count != 7'd0);
      if (r_state == S_DATA) w_get = ((r_byte_cnt + 7'd1) != r_count);
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_idx      = r_idx;
    w_nxt_shift    = r_shift;
    w_nxt_pid      = r_pid;
    w_nxt_ones     = r_ones;
    w_nxt_stuff    = r_stuff;
    w_nxt_count    = r_count;
    w_nxt_byte_cnt = r_byte_cnt;
    w_nxt_is_data  = r_is_data;
    w_nxt_line     = r_line;
    w_nxt_se0      = r_se0;
    w_err          = 1'b0;
    w_load         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_nxt_line = 1'b1;
        w_nxt_se0  = 1'b0;
        case (tx_packet)
          CMD_NONE: ;
          CMD_DATA0, CMD_DATA1: begin
            if (buffer_occupancy > MAX_P) begin
              w_err = 1'b1;
            end else begin
              w_nxt_state   = S_SYNC;
              w_nxt_is_data = 1'b1;
              w_nxt_count   = buffer_occupancy;
              w_nxt_pid     = (tx_packet == CMD_DATA0) ? PID_DATA0 : PID_DATA1;
            end
          end
          CMD_ACK, CMD_NAK, CMD_STALL: begin
            w_nxt_state   = S_SYNC;
            w_nxt_is_data = 1'b0;
            w_nxt_count   = 7'd0;
            w_nxt_pid     = (tx_packet == CMD_ACK) ? PID_ACK :
                            (tx_packet == CMD_NAK) ? PID_NAK : PID_STALL;
          end
          default: w_err = 1'b1;
        endcase
        if (w_nxt_state == S_SYNC) begin
          w_nxt_idx      = 3'd0;
          w_nxt_shift    = SYNC_BYTE;
          w_nxt_ones     = 3'd0;
          w_nxt_stuff    = 1'b0;
          w_nxt_byte_cnt = 7'd0;
          w_load         = 1'b1;
        end
      end

      S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI: begin
        if (w_tick) begin
          w_load = 1'b1;
          if (!r_stuff && w_raw && (r_ones == 3'd5)) begin
            w_nxt_stuff = 1'b1;
            w_nxt_ones  = 3'd0;
          end else begin
            w_nxt_stuff = 1'b0;
            w_nxt_ones  = w_raw ? (r_ones + 3'd1) : 3'd0;
            if (r_idx != 3'd7) begin
              w_nxt_idx = r_idx + 3'd1;
            end else begin
              w_nxt_idx = 3'd0;
              case (r_state)
                S_SYNC: begin
                  w_nxt_state = S_PID;
                  w_nxt_shift = r_pid;
                end
                S_PID: begin
                  if (!r_is_data) begin
                    w_nxt_state = S_EOP_SE0;
                  end else if (r_count != 7'd0) begin
                    w_nxt_state = S_DATA;
                    w_nxt_shift = r_next_byte;
                  end else begin
                    w_nxt_state = S_CRC_LO;
                    w_nxt_shift = w_crc[7:0];
                  end
                end
                S_DATA: begin
                  if ((r_byte_cnt + 7'd1) == r_count) begin
                    w_nxt_state = S_CRC_LO;
                    w_nxt_shift = w_crc[7:0];
                  end else begin
                    w_nxt_shift    = r_next_byte;
                    w_nxt_byte_cnt = r_byte_cnt + 7'd1;
                  end
                end
                S_CRC_LO: begin
                  w_nxt_state = S_CRC_HI;
                  w_nxt_shift = w_crc[15:8];
                end
                default: w_nxt_state = S_EOP_SE0;
              endcase
              if (w_nxt_state == S_EOP_SE0) begin
                w_load    = 1'b0;
                w_nxt_se0 = 1'b1;
              end
            end
          end
        end
      end

      S_EOP_SE0: begin
        if (w_tick) begin
          if (r_idx == 3'd1) begin
            w_nxt_state = S_EOP_J;
            w_nxt_idx   = 3'd0;
            w_nxt_se0   = 1'b0;
            w_nxt_line  = 1'b1;
          end else begin
            w_nxt_idx = r_idx + 3'd1;
          end
        end
      end

      default: begin
        if (w_tick) w_nxt_state = S_IDLE;
      end
    endcase

    // NRZI: a raw 0 flips the line at the start of its bit period.
    w_nxt_raw = w_nxt_stuff ? 1'b0 : w_nxt_shift[w_nxt_idx];
    if (w_load && !w_nxt_raw) w_nxt_line = ~w_nxt_line;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_next_byte <= 8'h00;
      r_pid       <= 8'h00;
      r_ones      <= 3'd0;
      r_stuff     <= 1'b0;
      r_count     <= 7'd0;
      r_byte_cnt  <= 7'd0;
      r_is_data   <= 1'b0;
      r_line      <= 1'b1;
      r_se0       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_clk_cnt   <= ((r_state == S_IDLE) || w_tick) ? '0 : r_clk_cnt + 1'b1;
      r_idx       <= w_nxt_idx;
      r_shift     <= w_nxt_shift;
      r_pid       <= w_nxt_pid;
      r_ones      <= w_nxt_ones;
      r_stuff     <= w_nxt_stuff;
      r_count     <= w_nxt_count;
      r_byte_cnt  <= w_nxt_byte_cnt;
      r_is_data   <= w_nxt_is_data;
      r_line      <= w_nxt_line;
      r_se0       <= w_nxt_se0;
      r_err       <= w_err;
      if (w_get) r_next_byte <= tx_packet_data;
    end
  end

  assign get_tx_packet_data = w_get;
  assign tx_transfer_active = (r_state != S_IDLE);
  assign tx_error           = r_err;
  assign dplus_out          = r_se0 ? 1'b0 : r_line;
  assign dminus_out         = r_se0 ? 1'b0 : ~r_line;

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: a bit-stream model builds the expected line waveform,
// pop strobes and activity per cycle, and one loop compares the DUT against it.
module tb_usb_tx;

  localparam int CPB  = 8;
  localparam int MAXN = 8192;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] tx_packet_data;
  logic       get, act, err, dp, dm;

  logic [7:0] mem [0:127];
  logic [6:0] ptr = 7'd0;
  assign tx_packet_data = mem[ptr];

  int checks = 0;
  int errors = 0;

  bit e_dp [MAXN];
  bit e_dm [MAXN];
  bit e_act[MAXN];
  bit e_get[MAXN];
  bit e_err[MAXN];
  int          m_total;
  logic [15:0] m_crc;

  usb_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get),
    .tx_transfer_active (act),
    .tx_error           (err),
    .dplus_out          (dp),
    .dminus_out         (dm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // USB CRC16 over mem[0..n-1]: init FFFF, reflected bitwise, result complemented.
  function automatic logic [15:0] crc_usb(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        c = ((c[0] ^ mem[i][j]) != 1'b0) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return ~c;
  endfunction

  task automatic build(input logic [2:0] cmd, input int cnt, input bit reject);
    logic [7:0] bq[$];
    bit         sb[$];
    bit         is_data, lvl, b;
    int         ones;
    for (int i = 0; i < MAXN; i++) begin
      e_dp[i] = 1'b1; e_dm[i] = 1'b0; e_act[i] = 1'b0; e_get[i] = 1'b0; e_err[i] = 1'b0;
    end
    m_total = 0;
    m_crc   = 16'h0;
    if (reject) begin
      e_err[0] = 1'b1;
      return;
    end
    is_data = (cmd == 3'd1) || (cmd == 3'd2);
    bq.push_back(8'h80);
    case (cmd)
      3'd1:    bq.push_back(8'hC3);
      3'd2:    bq.push_back(8'h4B);
      3'd3:    bq.push_back(8'hD2);
      3'd4:    bq.push_back(8'h5A);
      default: bq.push_back(8'h1E);
    endcase
    if (is_data) begin
      for (int i = 0; i < cnt; i++) bq.push_back(mem[i]);
      m_crc = crc_usb(cnt);
      bq.push_back(m_crc[7:0]);
      bq.push_back(m_crc[15:8]);
    end
    ones = 0;
    for (int k = 0; k < bq.size(); k++) begin
      for (int j = 0; j < 8; j++) begin
        b = bq[k][j];
        // Byte k (PID or payload) pre-fetches payload byte k-1 at the start of its bit 7.
        if (j == 7 && is_data && k >= 1 && k <= cnt) e_get[sb.size() * CPB] = 1'b1;
        sb.push_back(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          sb.push_back(1'b0);
          ones = 0;
        end
      end
    end
    lvl = 1'b1;
    for (int p = 0; p < sb.size(); p++) begin
      if (!sb[p]) lvl = ~lvl;
      for (int c = 0; c < CPB; c++) begin
        e_dp[p*CPB+c] = lvl; e_dm[p*CPB+c] = ~lvl; e_act[p*CPB+c] = 1'b1;
      end
    end
    for (int c = 0; c < 3 * CPB; c++) begin
      e_dp[sb.size()*CPB+c]  = (c >= 2 * CPB);
      e_dm[sb.size()*CPB+c]  = 1'b0;
      e_act[sb.size()*CPB+c] = 1'b1;
    end
    m_total = (sb.size() + 3) * CPB;
  endtask

  task automatic run(input string name, input logic [2:0] cmd, input int cnt,
                     input bit reject, input int mid_at);
    int gets;
    bit pend;
    bit is_data;
    gets = 0;
    pend = 1'b0;
    is_data = (cmd == 3'd1) || (cmd == 3'd2);
    build(cmd, cnt, reject);
    buffer_occupancy = 7'(cnt);
    ptr = 7'd0;
    @(negedge clk);
    tx_packet = cmd;
    for (int t = 0; t < m_total + 12; t++) begin
      @(negedge clk);
      if (t == 0) tx_packet = 3'd0;
      if (t == mid_at) tx_packet = 3'd5;
      else if (t == mid_at + 1) tx_packet = 3'd0;
      if (pend) begin
        ptr = ptr + 7'd1;
        pend = 1'b0;
      end
      checks++;
      if ({dp, dm, act, get, err} !== {e_dp[t], e_dm[t], e_act[t], e_get[t], e_err[t]}) begin
        errors++;
        if (errors <= 20)
          $display("FAIL %s cycle %0d: dp,dm,act,get,err got %b required %b", name, t,
                   {dp, dm, act, get, err}, {e_dp[t], e_dm[t], e_act[t], e_get[t], e_err[t]});
      end
      if (get === 1'b1) begin
        pend = 1'b1;
        gets++;
      end
    end
    chk({name, "_pops"}, gets, (!reject && is_data) ? cnt : 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {dp, dm, act, get, err}, 5'b10000);
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {dp, dm, act, get, err}, 5'b10000);
    end

    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    chk("crc_model_123456789", crc_usb(9), 16'hB4C8);

    build(3'd3, 0, 1'b0);
    chk("ack_model_cycles", m_total, 152);
    chk("ack_model_first_bit_k", {e_dp[0], e_dm[0]}, 2'b01);
    run("ack", 3'd3, 0, 1'b0, -5);

    build(3'd1, 0, 1'b0);
    chk("data0_empty_model_cycles", m_total, 280);
    chk("data0_empty_model_crc", m_crc, 16'h0000);
    run("data0_empty", 3'd1, 0, 1'b0, -5);

    mem[0] = 8'hFF;
    mem[1] = 8'hFF;
    build(3'd2, 2, 1'b0);
    chk("data1_ffff_model_crc", m_crc, 16'hFFFF);
    chk("data1_ffff_model_cycles", m_total, 448);
    run("data1_ffff", 3'd2, 2, 1'b0, -5);

    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 5);
    run("data0_64", 3'd1, 64, 1'b0, 300);

    run("reject_cmd6", 3'd6, 0, 1'b1, -5);
    run("reject_occ65", 3'd1, 65, 1'b1, -5);

    buffer_occupancy = 7'd4;
    ptr = 7'd0;
    @(negedge clk);
    tx_packet = 3'd1;
    @(negedge clk);
    tx_packet = 3'd0;
    repeat (199) @(negedge clk);
    chk("midpkt_active_before_reset", act, 1'b1);
    #2 n_rst = 1'b0;
    #1 chk("midpkt_reset_outputs", {dp, dm, act, get, err}, 5'b10000);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", {dp, dm, act, get, err}, 5'b10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
